// File: rtl/traffic_light_monitor.sv
// Passive checker for a RED -> YELLOW -> GREEN -> YELLOW -> RED lamp controller.
// Optional error counter output is enabled by defining TRAFFIC_MON_ERR_CNT_EN.
module traffic_light_monitor #(
    parameter int RED_TIME    = 50,
    parameter int YELLOW_TIME = 10,
    parameter int GREEN_TIME  = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red,
    input  logic        yellow,
    input  logic        green,
    output logic [2:0]  phase,
    output logic        in_sync,
    output logic        err_onehot,
    output logic        err_sequence,
    output logic        err_timing,
    output logic        fault,
`ifdef TRAFFIC_MON_ERR_CNT_EN
    output logic [7:0]  err_count,
`endif
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        RED_PH  = 3'd1,
        YEL1_PH = 3'd2,
        GRN_PH  = 3'd3,
        YEL2_PH = 3'd4
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [15:0] RED_EXP = 16'(RED_TIME + 1);
    localparam logic [15:0] YEL_EXP = 16'(YELLOW_TIME + 1);
    localparam logic [15:0] GRN_EXP = 16'(GREEN_TIME + 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    phase_t      state_q, state_d;
    logic [15:0] dwell_q, dwell_d;
    logic        untimed_q, untimed_d;
    logic        overrun_q, overrun_d;
    logic [15:0] cycles_q, cycles_d;
    logic        oh_d, seq_d, tim_d;
    logic [2:0]  lamps;
    logic        one_hot;
    logic [2:0]  same_lamp;
    logic [2:0]  succ_lamp;
    phase_t      succ_state;
    logic [15:0] exp_dwell;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            dwell_q      <= 16'd0;
            untimed_q    <= 1'b0;
            overrun_q    <= 1'b0;
            cycles_q     <= 16'd0;
            in_sync      <= 1'b0;
            err_onehot   <= 1'b0;
            err_sequence <= 1'b0;
            err_timing   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            untimed_q    <= untimed_d;
            overrun_q    <= overrun_d;
            cycles_q     <= cycles_d;
            in_sync      <= (state_d != SYNC);
            err_onehot   <= oh_d;
            err_sequence <= seq_d;
            err_timing   <= tim_d;
            fault        <= fault | oh_d | seq_d | tim_d;
        end
    end

    // Per-phase lamp expectations: the lamp that keeps the phase, and the one that advances it.
    always_comb begin
        same_lamp  = 3'b000;
        succ_lamp  = 3'b000;
        succ_state = SYNC;
        exp_dwell  = 16'd0;
        case (state_q)
            RED_PH: begin
                same_lamp  = LAMP_R;
                succ_lamp  = LAMP_Y;
                succ_state = YEL1_PH;
                exp_dwell  = RED_EXP;
            end
            YEL1_PH: begin
                same_lamp  = LAMP_Y;
                succ_lamp  = LAMP_G;
                succ_state = GRN_PH;
                exp_dwell  = YEL_EXP;
            end
            GRN_PH: begin
                same_lamp  = LAMP_G;
                succ_lamp  = LAMP_Y;
                succ_state = YEL2_PH;
                exp_dwell  = GRN_EXP;
            end
            YEL2_PH: begin
                same_lamp  = LAMP_Y;
                succ_lamp  = LAMP_R;
                succ_state = RED_PH;
                exp_dwell  = YEL_EXP;
            end
            default: ;
        endcase
    end

    always_comb begin
        lamps     = {red, yellow, green};
        one_hot   = (lamps == LAMP_R) || (lamps == LAMP_Y) || (lamps == LAMP_G);
        state_d   = state_q;
        dwell_d   = dwell_q;
        untimed_d = untimed_q;
        overrun_d = overrun_q;
        cycles_d  = cycles_q;
        oh_d      = 1'b0;
        seq_d     = 1'b0;
        tim_d     = 1'b0;

        if (!one_hot) begin
            oh_d      = 1'b1;
            state_d   = SYNC;
            dwell_d   = 16'd0;
            overrun_d = 1'b0;
        end else if (state_q == SYNC) begin
            // Only red can resync; the partial red we land in is not timed.
            if (lamps == LAMP_R) begin
                state_d   = RED_PH;
                dwell_d   = 16'd1;
                untimed_d = 1'b1;
                overrun_d = 1'b0;
            end
        end else if (lamps == same_lamp) begin
            dwell_d = sat_inc16(dwell_q);
            if (!untimed_q && !overrun_q && (dwell_q == exp_dwell)) begin
                tim_d     = 1'b1;
                overrun_d = 1'b1;
            end
        end else if (lamps == succ_lamp) begin
            state_d   = succ_state;
            dwell_d   = 16'd1;
            untimed_d = 1'b0;
            overrun_d = 1'b0;
            if (!untimed_q && !overrun_q && (dwell_q != exp_dwell)) begin
                tim_d = 1'b1;
            end
            if (state_q == YEL2_PH) begin
                cycles_d = cycles_q + 16'd1;
            end
        end else begin
            seq_d     = 1'b1;
            state_d   = SYNC;
            dwell_d   = 16'd0;
            overrun_d = 1'b0;
        end
    end

`ifdef TRAFFIC_MON_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if ((oh_d | seq_d | tim_d) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    assign phase       = state_q;
    assign cycle_count = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor with short dwell parameters (5/2/5).
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, NONE = 3'b000;
    localparam logic [2:0] E_OH = 3'b100, E_SQ = 3'b010, E_TM = 3'b001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic [2:0]  phase;
    logic        in_sync, err_onehot, err_sequence, err_timing, fault;
    logic [15:0] cycle_count;
`ifdef TRAFFIC_MON_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    traffic_light_monitor #(
        .RED_TIME(5), .YELLOW_TIME(2), .GREEN_TIME(5)
    ) dut (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
        .phase(phase), .in_sync(in_sync), .err_onehot(err_onehot),
        .err_sequence(err_sequence), .err_timing(err_timing), .fault(fault),
`ifdef TRAFFIC_MON_ERR_CNT_EN
        .err_count(err_count),
`endif
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  errs;
        bit          full;
        logic [2:0]  phase;
        logic        in_sync;
        logic        fault;
        logic [15:0] cnt;
        bit          chk_ecnt;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t sbq[$];
    int   ncyc = 0;
    int   tests = 0;
    int   failures = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, ncyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and checks the matching entry.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            ncyc++;
            while (sbq.size() > 0 && sbq[0].cyc < ncyc) begin
                x = sbq.pop_front();
                cmp("stale_entry", 16'(x.cyc), 16'(ncyc));
            end
            if (sbq.size() > 0 && sbq[0].cyc == ncyc) begin
                x = sbq.pop_front();
                cmp("err_bits", {13'd0, err_onehot, err_sequence, err_timing}, {13'd0, x.errs});
                if (x.full) begin
                    cmp("phase", {13'd0, phase}, {13'd0, x.phase});
                    cmp("in_sync", {15'd0, in_sync}, {15'd0, x.in_sync});
                    cmp("fault", {15'd0, fault}, {15'd0, x.fault});
                    cmp("cycle_count", cycle_count, x.cnt);
                end
`ifdef TRAFFIC_MON_ERR_CNT_EN
                if (x.chk_ecnt) cmp("err_count", {8'd0, err_count}, {8'd0, x.ecnt});
`endif
            end
        end
    end

    function automatic exp_t mk(input logic [2:0] e);
        exp_t x;
        x.cyc = ncyc + 1;
        x.errs = e;
        x.full = 1'b0;
        x.phase = 3'd0;
        x.in_sync = 1'b0;
        x.fault = 1'b0;
        x.cnt = 16'd0;
        x.chk_ecnt = 1'b0;
        x.ecnt = 8'd0;
        return x;
    endfunction

    task automatic step(input logic [2:0] l, input logic [2:0] e);
        @(negedge clk);
        reset = 1'b0;
        {red, yellow, green} = l;
        sbq.push_back(mk(e));
    endtask

    task automatic lamps(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 3'b000);
    endtask

    // Attach full-state expectations to the most recently issued sample.
    task automatic chk(input logic [2:0] ph, input logic sync, input logic flt, input logic [15:0] cnt);
        exp_t x;
        x = sbq.pop_back();
        x.full = 1'b1;
        x.phase = ph;
        x.in_sync = sync;
        x.fault = flt;
        x.cnt = cnt;
        sbq.push_back(x);
    endtask

    task automatic chk_ecnt(input logic [7:0] v);
        exp_t x;
        x = sbq.pop_back();
        x.chk_ecnt = 1'b1;
        x.ecnt = v;
        sbq.push_back(x);
    endtask

    task automatic rst_step();
        exp_t x;
        @(negedge clk);
        reset = 1'b1;
        {red, yellow, green} = NONE;
        x = mk(3'b000);
        x.full = 1'b1;
        x.chk_ecnt = 1'b1;
        sbq.push_back(x);
    endtask

    // Reset, then run one untimed cycle so the monitor sits in a timed RED (dwell 1, count 1).
    task automatic to_timed();
        rst_step();
        step(R, 3'b000);
        lamps(R, 5); lamps(Y, 3); lamps(G, 6); lamps(Y, 3);
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b0, 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_step(); rst_step();

        // Legal sequence, three full periods.
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b0, 16'd0);
        lamps(R, 5);
        step(Y, 3'b000); chk(3'd2, 1'b1, 1'b0, 16'd0);
        lamps(Y, 2);
        step(G, 3'b000); chk(3'd3, 1'b1, 1'b0, 16'd0);
        lamps(G, 5);
        step(Y, 3'b000); chk(3'd4, 1'b1, 1'b0, 16'd0);
        lamps(Y, 2);
        for (int p = 0; p < 2; p++) begin
            step(R, 3'b000); chk(3'd1, 1'b1, 1'b0, 16'(p + 1));
            lamps(R, 5); lamps(Y, 3); lamps(G, 6); lamps(Y, 3);
        end
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b0, 16'd3);

        // Green too short.
        to_timed();
        lamps(R, 5); lamps(Y, 3); lamps(G, 4);
        step(Y, E_TM); chk(3'd4, 1'b1, 1'b1, 16'd1);
        lamps(Y, 2);
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b1, 16'd2);
        lamps(R, 5);
        step(Y, 3'b000); chk(3'd2, 1'b1, 1'b1, 16'd2);

        // Red overrun: single pulse on the 7th sample, no extra error on leaving.
        to_timed();
        lamps(R, 5); chk(3'd1, 1'b1, 1'b0, 16'd1);
        step(R, E_TM); chk(3'd1, 1'b1, 1'b1, 16'd1);
        step(R, 3'b000);
        step(Y, 3'b000); chk(3'd2, 1'b1, 1'b1, 16'd1);
        lamps(Y, 2);
        step(G, 3'b000); chk(3'd3, 1'b1, 1'b1, 16'd1);

        // Illegal transitions and resync.
        to_timed();
        step(G, E_SQ); chk(3'd0, 1'b0, 1'b1, 16'd1);
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b1, 16'd1);
        lamps(R, 9);
        step(Y, 3'b000); chk(3'd2, 1'b1, 1'b1, 16'd1);
        step(R, E_SQ); chk(3'd0, 1'b0, 1'b1, 16'd1);
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b1, 16'd1);

        // One-hot violations take priority; yellow/green ignored in SYNC.
        to_timed();
        lamps(R, 5); lamps(Y, 3);
        step(G, 3'b000); chk(3'd3, 1'b1, 1'b0, 16'd1);
        step(3'b101, E_OH); chk(3'd0, 1'b0, 1'b1, 16'd1);
        step(NONE, E_OH); chk(3'd0, 1'b0, 1'b1, 16'd1);
        step(Y, 3'b000); chk(3'd0, 1'b0, 1'b1, 16'd1);
        step(G, 3'b000);
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b1, 16'd1);

        // Reset in GRN with fault set and two completed cycles.
        to_timed();
        lamps(R, 5); lamps(Y, 3); lamps(G, 6); lamps(Y, 3);
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b0, 16'd2);
        lamps(R, 5); lamps(Y, 3); lamps(G, 6);
        step(G, E_TM); chk(3'd3, 1'b1, 1'b1, 16'd2);
        rst_step();
        step(R, 3'b000); chk(3'd1, 1'b1, 1'b0, 16'd0);

`ifdef TRAFFIC_MON_ERR_CNT_EN
        rst_step();
        for (int i = 1; i <= 300; i++) begin
            step(NONE, E_OH);
            if (i == 10) chk_ecnt(8'd10);
            if (i == 255) chk_ecnt(8'd255);
        end
        chk_ecnt(8'd255);
        rst_step();
`endif

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
